// File: rtl/bcd_pkg.sv
//------------------------------------------------------------------------------
// Module   : bcd_pkg
// Brief    : Shared types and helpers for the BCD-to-binary converter.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  // Smallest binary width holding 10**digits - 1.
  function automatic int bin_width(input int digits);
    case (digits)
      1:       return 4;
      2:       return 7;
      3:       return 10;
      default: return 14;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_nibble_adjust.sv
//------------------------------------------------------------------------------
// Module   : bcd_nibble_adjust
// Brief    : Reverse double-dabble digit correction: x >= 8 ? x - 3 : x.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bcd_nibble_adjust (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = din[3] ? (din - 4'd3) : din;

endmodule

`default_nettype wire

// File: rtl/bcd2bin_seq.sv
//------------------------------------------------------------------------------
// Module   : bcd2bin_seq
// Brief    : Sequential packed-BCD to binary converter with start/busy/done.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bcd2bin_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int W      = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic [W-1:0]          bin_out,
  output logic                  busy,
  output logic                  done,
  output logic                  invalid
);

  localparam int N  = 4 * DIGITS;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] c_last_cnt = CW'(N - 1);

  state_t          r_state;
  logic [N-1:0]    r_bcd_sr;
  logic [N-1:0]    r_bin_sr;
  logic [CW-1:0]   r_cnt;

  logic [2*N-1:0]  w_shifted;
  logic [N-1:0]    w_bcd_shift;
  logic [N-1:0]    w_bin_shift;
  logic [N-1:0]    w_bcd_adj;
  logic [DIGITS-1:0] w_digit_bad;
  logic            w_any_bad;

  assign w_shifted   = {r_bcd_sr, r_bin_sr} >> 1;
  assign w_bcd_shift = w_shifted[2*N-1:N];
  assign w_bin_shift = w_shifted[N-1:0];
  assign w_any_bad   = |w_digit_bad;

  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      bcd_nibble_adjust u_adjust (
        .din  (w_bcd_shift[4*i +: 4]),
        .dout (w_bcd_adj[4*i +: 4])
      );
      assign w_digit_bad[i] = (bcd_in[4*i +: 4] > BCD_MAX_DIGIT);
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_bcd_sr <= '0;
      r_bin_sr <= '0;
      r_cnt    <= '0;
      bin_out  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      invalid  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            invalid <= 1'b0;
            if (w_any_bad) begin
              // Rejected words skip the shift phase entirely.
              invalid <= 1'b1;
              bin_out <= '0;
              done    <= 1'b1;
              r_state <= DONE;
            end else begin
              r_bcd_sr <= bcd_in;
              r_bin_sr <= '0;
              r_cnt    <= '0;
              busy     <= 1'b1;
              r_state  <= SHIFT;
            end
          end
        end
        SHIFT: begin
          r_bcd_sr <= w_bcd_adj;
          r_bin_sr <= w_bin_shift;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == c_last_cnt) begin
            // After N shifts the full value sits in bin_sr; its top N-W bits are zero.
            bin_out <= w_bin_shift[W-1:0];
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bcd2bin_seq.sv
//------------------------------------------------------------------------------
// Module   : tb_bcd2bin_seq
// Brief    : Self-checking bench for bcd2bin_seq (DIGITS=4).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_bcd2bin_seq;
  import bcd_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] bcd_in = '0;
  logic [13:0] bin_out;
  logic        busy;
  logic        done;
  logic        invalid;

  int n_checks = 0;
  int n_errors = 0;

  bcd2bin_seq #(.DIGITS(4), .W(14)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .bcd_in  (bcd_in),
    .bin_out (bin_out),
    .busy    (busy),
    .done    (done),
    .invalid (invalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bcd;
    int          bin;
    int          inv;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // k = index of the edge after E0 whose following cycle shows done.
  task automatic run_conv(input logic [15:0] b, output int k, output int bc);
    @(negedge clk);
    start  = 1'b1;
    bcd_in = b;
    @(negedge clk);
    start = 1'b0;
    k  = 0;
    bc = 0;
    while (!done && k < 40) begin
      if (busy) bc++;
      @(negedge clk);
      k++;
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[3:0]   = 4'(v % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[15:12] = 4'((v / 1000) % 10);
    return r;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[11];
    int   k, bc, ndone;

    vecs[0]  = '{16'h0000, 0,    0};
    vecs[1]  = '{16'h9999, 9999, 0};
    vecs[2]  = '{16'h1234, 1234, 0};
    vecs[3]  = '{16'h12A4, 0,    1};
    vecs[4]  = '{16'h0042, 42,   0};
    vecs[5]  = '{16'h0001, 1,    0};
    vecs[6]  = '{16'h0010, 10,   0};
    vecs[7]  = '{16'h8765, 8765, 0};
    vecs[8]  = '{16'hF000, 0,    1};
    vecs[9]  = '{16'h0009, 9,    0};
    vecs[10] = '{16'h000A, 0,    1};

    // Reset state
    #12;
    chk("reset_bin_out", int'(bin_out), 0);
    chk("reset_busy",    int'(busy),    0);
    chk("reset_done",    int'(done),    0);
    chk("reset_invalid", int'(invalid), 0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      run_conv(vecs[i].bcd, k, bc);
      chk($sformatf("vec%0d_latency", i), k,  vecs[i].inv ? 0 : 16);
      chk($sformatf("vec%0d_busy_cycles", i), bc, vecs[i].inv ? 0 : 16);
      chk($sformatf("vec%0d_bin_out", i), int'(bin_out), vecs[i].bin);
      chk($sformatf("vec%0d_invalid", i), int'(invalid), vecs[i].inv);
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", i), int'(done), 0);
      chk($sformatf("vec%0d_held_bin", i), int'(bin_out), vecs[i].bin);
    end

    // Extra start pulse during shift 5 is ignored
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 16'h0500;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    k = 0;
    for (int c = 0; c < 24; c++) begin
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          chk("ign_latency", k, 16);
          chk("ign_bin_out", int'(bin_out), 500);
        end
      end
      if (k == 5) begin
        start  = 1'b1;
        bcd_in = 16'h0077;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    chk("ign_done_count", ndone, 1);
    chk("ign_idle_busy", int'(busy), 0);

    // Start held high through DONE: accepted in the following IDLE cycle
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 16'h0007;
    @(negedge clk);
    bcd_in = 16'h0025;
    k = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("held_first_latency", k, 16);
    chk("held_first_bin", int'(bin_out), 7);
    @(negedge clk);
    chk("held_idle_busy", int'(busy), 0);
    chk("held_idle_done", int'(done), 0);
    @(negedge clk);
    chk("held_accept_busy", int'(busy), 1);
    start = 1'b0;
    k = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("held_second_latency", k, 16);
    chk("held_second_bin", int'(bin_out), 25);

    // Reset after shift 7
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 16'h8765;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid_busy_before_reset", int'(busy), 1);
    reset = 1'b1;
    #1;
    chk("mid_reset_bin_out", int'(bin_out), 0);
    chk("mid_reset_busy",    int'(busy),    0);
    chk("mid_reset_done",    int'(done),    0);
    chk("mid_reset_invalid", int'(invalid), 0);
    chk("mid_reset_state",   int'(dut.r_state), int'(IDLE));
    @(negedge clk);
    reset = 1'b0;
    run_conv(16'h0001, k, bc);
    chk("post_reset_latency", k, 16);
    chk("post_reset_bin", int'(bin_out), 1);

    // Round trip 0..1023
    for (int v = 0; v < 1024; v++) begin
      run_conv(to_bcd(v), k, bc);
      chk($sformatf("rt%0d_bin", v), int'(bin_out), v);
      chk($sformatf("rt%0d_invalid", v), int'(invalid), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
